// File: rtl/mmio_panel.sv
// Memory-mapped front panel: hex digits, blanking, LEDs, debounced push buttons and run control.
// Latency: register writes are visible on digits/blank/leds after the write edge; q/hit lag address by one cycle.
// Backpressure: none; the CPU port accepts one access every cycle.
module mmio_panel #(
    parameter int              AW   = 16,
    parameter logic [AW-1:0]   BASE = 16'hFFFC,
    parameter int              NDIG = 4,
    parameter int              NBTN = 4,
    parameter int              DEB  = 16
) (
    input  logic                clock,
    input  logic                nRst,
    input  logic [AW-1:0]       address,
    input  logic [31:0]         data,
    input  logic                wren,
    output logic [31:0]         q,
    output logic                hit,
    input  logic [NBTN-1:0]     BUTTON,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     blank,
    output logic [7:0]          leds,
    output logic                run
);

    localparam int CW = (DEB > 2) ? $clog2(DEB) : 1;

    localparam logic [1:0] OFF_DISP  = 2'd0;
    localparam logic [1:0] OFF_BLANK = 2'd1;
    localparam logic [1:0] OFF_LED   = 2'd2;
    localparam logic [1:0] OFF_BTN   = 2'd3;

    logic                in_win;
    logic                wr_en;
    logic [1:0]          off;
    logic [4*NDIG-1:0]   disp_r;
    logic [NDIG-1:0]     blank_r;
    logic [7:0]          led_r;
    logic [NBTN-1:0]     flag;
    logic [NBTN-1:0]     flag_clr;
    logic [NBTN-1:0]     sync1;
    logic [NBTN-1:0]     sync2;
    logic [NBTN-1:0]     pressed_s;
    logic [NBTN-1:0]     lvl;
    logic [NBTN-1:0]     done;
    logic [NBTN-1:0]     rise;
    logic [CW-1:0]       cnt [NBTN];
    logic [31:0]         btn_word;
    logic [31:0]         rd_mux;
    logic                unused_data;

    assign in_win      = (address[AW-1:2] == BASE[AW-1:2]);
    assign wr_en       = wren & in_win;
    assign off         = address[1:0];
    assign unused_data = ^data;

    assign digits = disp_r;
    assign blank  = blank_r;
    assign leds   = led_r;

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            disp_r  <= '0;
            blank_r <= '0;
            led_r   <= '0;
        end else if (wr_en) begin
            case (off)
                OFF_DISP:  disp_r  <= data[4*NDIG-1:0];
                OFF_BLANK: blank_r <= data[NDIG-1:0];
                OFF_LED:   led_r   <= data[7:0];
                default:   ;
            endcase
        end
    end

    // Raw buttons are active-low; everything past the synchroniser uses 1 = pressed.
    always_comb begin
        pressed_s = ~sync2;
        done      = '0;
        rise      = '0;
        for (int i = 0; i < NBTN; i++) begin
            done[i] = (pressed_s[i] != lvl[i]) && (cnt[i] == CW'(DEB - 1));
            rise[i] = done[i] & pressed_s[i];
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            sync1 <= '1;
            sync2 <= '1;
            lvl   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= BUTTON;
            sync2 <= sync1;
            for (int i = 0; i < NBTN; i++) begin
                if (pressed_s[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (done[i]) begin
                    lvl[i] <= pressed_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A press edge landing in the same cycle as its W1C keeps the flag set.
    assign flag_clr = (wr_en && off == OFF_BTN) ? data[NBTN-1:0] : '0;

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            flag <= '0;
        end else begin
            flag <= (flag & ~flag_clr) | rise;
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            run <= 1'b0;
        end else if (lvl[1]) begin
            run <= 1'b0;
        end else if (lvl[0]) begin
            run <= 1'b1;
        end
    end

    assign btn_word = 32'(flag) | (32'(lvl) << 8);

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_DISP:  rd_mux = 32'(disp_r);
            OFF_BLANK: rd_mux = 32'(blank_r);
            OFF_LED:   rd_mux = 32'(led_r);
            default:   rd_mux = btn_word;
        endcase
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            q   <= '0;
            hit <= 1'b0;
        end else begin
            q   <= in_win ? rd_mux : 32'h0;
            hit <= in_win;
        end
    end

endmodule

// File: tb/tb_mmio_panel.sv
// Bench for mmio_panel: directed vectors, expected values queued at issue time and checked by a monitor.
module tb_mmio_panel;

    logic        clock = 1'b0;
    logic        nRst, nRst8;
    logic [15:0] address, address8;
    logic [31:0] data, data8;
    logic        wren, wren8;
    logic [31:0] q, q8;
    logic        hit, hit8;
    logic [3:0]  BUTTON, button8;
    logic [15:0] digits;
    logic [31:0] digits8;
    logic [3:0]  blank;
    logic [7:0]  blank8;
    logic [7:0]  leds, leds8;
    logic        run, run8;

    always #5 clock = ~clock;

    mmio_panel dut (
        .clock(clock), .nRst(nRst), .address(address), .data(data), .wren(wren),
        .q(q), .hit(hit), .BUTTON(BUTTON), .digits(digits), .blank(blank),
        .leds(leds), .run(run)
    );

    mmio_panel #(.NDIG(8)) dut8 (
        .clock(clock), .nRst(nRst8), .address(address8), .data(data8), .wren(wren8),
        .q(q8), .hit(hit8), .BUTTON(button8), .digits(digits8), .blank(blank8),
        .leds(leds8), .run(run8)
    );

    typedef enum int {K_Q, K_HIT, K_DIG, K_BLK, K_LED, K_RUN,
                      K_Q8, K_HIT8, K_DIG8, K_BLK8, K_LED8} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        int          due;
        string       name;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(kind_t k);
        case (k)
            K_Q:    return q;
            K_HIT:  return {31'b0, hit};
            K_DIG:  return {16'b0, digits};
            K_BLK:  return {28'b0, blank};
            K_LED:  return {24'b0, leds};
            K_RUN:  return {31'b0, run};
            K_Q8:   return q8;
            K_HIT8: return {31'b0, hit8};
            K_DIG8: return digits8;
            K_BLK8: return {24'b0, blank8};
            default: return {24'b0, leds8};
        endcase
    endfunction

    item_t       it;
    logic [31:0] act;
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it  = sb.pop_front();
            act = actual(it.kind);
            vectors++;
            if (act !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    // Queue a check of the DUT state seen after the next rising edge.
    task automatic push_exp(kind_t k, logic [31:0] e, string n);
        sb.push_back('{k, e, cyc + 1, n});
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(logic [15:0] a, logic [31:0] d);
        address = a; data = d; wren = 1'b1;
        tick(1);
        wren = 1'b0;
    endtask

    task automatic rd(logic [15:0] a, logic [31:0] eq, logic eh, string n);
        address = a; wren = 1'b0;
        push_exp(K_Q, eq, {n, ".q"});
        push_exp(K_HIT, {31'b0, eh}, {n, ".hit"});
        tick(1);
    endtask

    task automatic wr8(logic [15:0] a, logic [31:0] d);
        address8 = a; data8 = d; wren8 = 1'b1;
        tick(1);
        wren8 = 1'b0;
    endtask

    initial begin
        nRst = 1'b0; nRst8 = 1'b0;
        address = 16'hFFFC; data = '0; wren = 1'b0; BUTTON = 4'hF;
        address8 = 16'h0000; data8 = '0; wren8 = 1'b0; button8 = 4'hF;
        tick(1);
        push_exp(K_Q,   32'h0, "rst.q");
        push_exp(K_HIT, 32'h0, "rst.hit");
        push_exp(K_DIG, 32'h0, "rst.digits");
        push_exp(K_BLK, 32'h0, "rst.blank");
        push_exp(K_LED, 32'h0, "rst.leds");
        push_exp(K_RUN, 32'h0, "rst.run");
        tick(2);
        nRst = 1'b1; nRst8 = 1'b1;
        tick(2);

        push_exp(K_DIG, 32'h0000BEEF, "disp.digits");
        wr(16'hFFFC, 32'h0000BEEF);
        rd(16'hFFFC, 32'h0000BEEF, 1'b1, "disp.rd");
        wr(16'hFFFC, 32'h1234ABCD);
        rd(16'hFFFC, 32'h0000ABCD, 1'b1, "disp.rd_mask");
        wr(16'hFFFD, 32'hFFFFFFFF);
        rd(16'hFFFD, 32'h0000000F, 1'b1, "blank.rd");
        push_exp(K_BLK, 32'hF, "blank.out");
        wr(16'hFFFE, 32'h000001A5);
        rd(16'hFFFE, 32'h000000A5, 1'b1, "led.rd");
        push_exp(K_LED, 32'hA5, "led.out");

        wr(16'hFFF8, 32'hFFFFFFFF);
        rd(16'hFFF8, 32'h0, 1'b0, "oow.rd");
        push_exp(K_DIG, 32'h0000ABCD, "oow.digits");
        push_exp(K_BLK, 32'hF, "oow.blank");
        push_exp(K_LED, 32'hA5, "oow.leds");
        tick(1);

        BUTTON[2] = 1'b0; tick(10); BUTTON[2] = 1'b1;
        tick(20);
        rd(16'hFFFF, 32'h0, 1'b1, "glitch.btn");

        BUTTON[2] = 1'b0; tick(18);
        rd(16'hFFFF, 32'h00000404, 1'b1, "press2.btn");
        wr(16'hFFFF, 32'h4);
        BUTTON[2] = 1'b1;
        rd(16'hFFFF, 32'h00000400, 1'b1, "w1c2.btn");
        tick(25);
        rd(16'hFFFF, 32'h0, 1'b1, "release2.btn");

        push_exp(K_RUN, 32'h0, "run.idle");
        BUTTON[0] = 1'b0; tick(20);
        push_exp(K_RUN, 32'h1, "run.go");
        tick(1);
        BUTTON[1] = 1'b0; tick(20);
        push_exp(K_RUN, 32'h0, "run.halt_wins");
        tick(1);
        BUTTON[1:0] = 2'b11; tick(25);
        push_exp(K_RUN, 32'h0, "run.hold");
        rd(16'hFFFF, 32'h00000003, 1'b1, "run.flags");
        wr(16'hFFFF, 32'h3);
        rd(16'hFFFF, 32'h0, 1'b1, "run.flags_clr");

        BUTTON[3] = 1'b0; tick(17);
        wr(16'hFFFF, 32'h8);
        rd(16'hFFFF, 32'h00000808, 1'b1, "setwins.btn");
        BUTTON[3] = 1'b1; tick(25);
        wr(16'hFFFF, 32'h8);
        rd(16'hFFFF, 32'h0, 1'b1, "setwins.clr");

        push_exp(K_DIG8, 32'h12345678, "n8.digits");
        wr8(16'hFFFC, 32'h12345678);
        push_exp(K_BLK8, 32'h000000F0, "n8.blank");
        wr8(16'hFFFD, 32'h000000F0);
        wr8(16'hFFFE, 32'h0000005A);
        address8 = 16'hFFFC;
        push_exp(K_Q8,   32'h12345678, "n8.q");
        push_exp(K_HIT8, 32'h1, "n8.hit");
        push_exp(K_LED8, 32'h5A, "n8.leds");
        tick(2);
        @(posedge clock);
        #2 nRst8 = 1'b0;
        sb.push_back('{K_DIG8, 32'h0, cyc, "n8rst.digits"});
        sb.push_back('{K_BLK8, 32'h0, cyc, "n8rst.blank"});
        sb.push_back('{K_LED8, 32'h0, cyc, "n8rst.leds"});
        sb.push_back('{K_Q8,   32'h0, cyc, "n8rst.q"});
        sb.push_back('{K_HIT8, 32'h0, cyc, "n8rst.hit"});
        tick(3);
        nRst8 = 1'b1;
        tick(2);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
